// File: rtl/tx_sched_pkg.sv
// Shared definitions for the TX weighted round-robin scheduler:
// FSM state type, default weight width and the weight-to-credit mapping.
package tx_sched_pkg;

    typedef enum logic {
        IDLE,
        BUSY
    } sched_state_e;

    localparam int TX_SCHED_W_DEF = 4;

    // A weight of zero would starve a requester, so it is granted one packet.
    function automatic int unsigned eff_weight(input int unsigned w);
        return (w == 0) ? 1 : w;
    endfunction

endpackage

// File: rtl/tx_wrr_sched_if.sv
// Request/grant bundle between the queue-pair requesters, the TX payload mux
// and the weighted round-robin scheduler. The slave modport is the scheduler.
interface tx_wrr_sched_if
    import tx_sched_pkg::*;
#(
    parameter int N_REQ   = 4,
    parameter int W_WIDTH = TX_SCHED_W_DEF
);
    localparam int ID_W = $clog2(N_REQ);

    logic                     sched_en;
    logic [N_REQ-1:0]         req;
    logic [N_REQ*W_WIDTH-1:0] weight;
    logic                     beat_acc;
    logic                     beat_last;
    logic [N_REQ-1:0]         gnt;
    logic                     gnt_vld;
    logic [ID_W-1:0]          gnt_id;

    modport master (
        output sched_en, req, weight, beat_acc, beat_last,
        input  gnt, gnt_vld, gnt_id
    );

    modport slave (
        input  sched_en, req, weight, beat_acc, beat_last,
        output gnt, gnt_vld, gnt_id
    );

endinterface

// File: rtl/rr_mask_pick.sv
// Round-robin pick: lowest requester at or above ptr, wrapping to the lowest
// requester overall when nothing at or above ptr is pending.
module rr_mask_pick #(
    parameter int N_REQ = 4,
    parameter int ID_W  = $clog2(N_REQ)
) (
    input  logic [N_REQ-1:0] req,
    input  logic [ID_W-1:0]  ptr,
    output logic [N_REQ-1:0] pick,
    output logic [ID_W-1:0]  pick_id,
    output logic             none
);

    logic [N_REQ-1:0] mask;
    logic [N_REQ-1:0] masked;
    logic [N_REQ-1:0] sel;

    // Thermometer mask from ptr, then a lowest-set-bit search on the chosen vector.
    always_comb begin
        mask    = '0;
        pick    = '0;
        pick_id = '0;
        for (int i = 0; i < N_REQ; i++) begin
            mask[i] = (i >= int'(ptr));
        end
        masked = req & mask;
        sel    = (|masked) ? masked : req;
        for (int i = N_REQ - 1; i >= 0; i--) begin
            if (sel[i]) begin
                pick_id = ID_W'(i);
            end
        end
        if (|sel) begin
            pick[pick_id] = 1'b1;
        end
        none = ~|req;
    end

endmodule

// File: rtl/tx_wrr_sched.sv
// Packet-granular weighted round-robin scheduler for the TX datapath.
// A grant is held until the packet's last beat is accepted; a requester keeps
// the grant for up to weight[i] consecutive packets before rotation moves on.
// Build option TX_WRR_WEIGHT_EN: when defined, per-requester weights set the
// turn length; when undefined, weight is ignored and every turn is one packet.
module tx_wrr_sched
    import tx_sched_pkg::*;
#(
    parameter int N_REQ   = 4,
    parameter int W_WIDTH = TX_SCHED_W_DEF
) (
    input logic           sys_clk,
    input logic           sys_rst,
    tx_wrr_sched_if.slave bus
);

    localparam int ID_W = $clog2(N_REQ);

    sched_state_e       state;
    logic [ID_W-1:0]    ptr;
    logic [W_WIDTH-1:0] credit;
    logic [W_WIDTH-1:0] load_credit;
    logic [ID_W-1:0]    next_ptr;
    logic [ID_W-1:0]    pick_ptr;
    logic [N_REQ-1:0]   pick;
    logic [ID_W-1:0]    pick_id;
    logic               none;
    logic               pkt_end;
    logic               keep_turn;

    // Rotation point after the current grantee. Searching all of req from there
    // puts the current grantee last, so it is only re-picked when it is alone.
    always_comb begin
        next_ptr  = (bus.gnt_id == ID_W'(N_REQ - 1)) ? '0 : bus.gnt_id + 1'b1;
        pick_ptr  = (state == BUSY) ? next_ptr : ptr;
        pkt_end   = bus.beat_acc & bus.beat_last;
        keep_turn = (credit > W_WIDTH'(1)) & bus.req[bus.gnt_id] & bus.sched_en;
    end

`ifdef TX_WRR_WEIGHT_EN
    // Turn length comes from the picked requester's weight, sampled at turn start.
    always_comb begin
        load_credit = W_WIDTH'(eff_weight(int'(bus.weight[pick_id*W_WIDTH +: W_WIDTH])));
    end
`else
    // Plain round-robin: every turn lasts exactly one packet.
    always_comb begin
        load_credit = W_WIDTH'(1);
    end
`endif

    rr_mask_pick #(
        .N_REQ (N_REQ),
        .ID_W  (ID_W)
    ) u_pick (
        .req     (bus.req),
        .ptr     (pick_ptr),
        .pick    (pick),
        .pick_id (pick_id),
        .none    (none)
    );

    // Grant FSM: start a turn from IDLE, and on each packet end either continue
    // the turn, hand over without a bubble, or drop back to IDLE.
    always_ff @(posedge sys_clk or posedge sys_rst) begin
        if (sys_rst) begin
            state       <= IDLE;
            ptr         <= '0;
            credit      <= '0;
            bus.gnt     <= '0;
            bus.gnt_vld <= 1'b0;
            bus.gnt_id  <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (bus.sched_en && !none) begin
                        bus.gnt     <= pick;
                        bus.gnt_id  <= pick_id;
                        bus.gnt_vld <= 1'b1;
                        credit      <= load_credit;
                        state       <= BUSY;
                    end
                end
                BUSY: begin
                    if (pkt_end) begin
                        if (keep_turn) begin
                            credit <= credit - 1'b1;
                        end else begin
                            ptr <= next_ptr;
                            if (bus.sched_en && !none) begin
                                bus.gnt    <= pick;
                                bus.gnt_id <= pick_id;
                                credit     <= load_credit;
                            end else begin
                                bus.gnt     <= '0;
                                bus.gnt_vld <= 1'b0;
                                bus.gnt_id  <= '0;
                                credit      <= credit - 1'b1;
                                state       <= IDLE;
                            end
                        end
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: doc/tx_wrr_sched.md
# tx_wrr_sched

Packet-granular weighted round-robin scheduler that shares the TX datapath among `N_REQ` queue-pair requesters for per-QP isolation. It sits in front of the TX payload mux and grants one requester at a time. The grant is held until the granted packet's last beat is accepted. A granted requester keeps the grant for up to `weight[i]` consecutive packets, then rotation moves past it.

## Interface
- `N_REQ`, default 4: number of requesters, ≥2.
- `W_WIDTH`, default 4: width of each weight field.
- `sys_clk`  in  1  clock.
- `sys_rst`  in  1  reset, asynchronous, active-high.
- `sched_en`  in  1  allows new grants. A packet in flight always completes.
- `req`  in  N_REQ  requester i has a packet pending. It must stay high until the packet's last beat is accepted.
- `weight`  in  N_REQ*W_WIDTH  packets per turn. Field i is `[i*W_WIDTH +: W_WIDTH]`. It is sampled when a turn starts.
- `beat_acc`  in  1  downstream accepted one beat of the granted packet.
- `beat_last`  in  1  the accepted beat is the packet's last. Qualified by `beat_acc`.
- `gnt`  out  N_REQ  one-hot grant, registered.
- `gnt_vld`  out  1  `gnt` is valid, registered.
- `gnt_id`  out  $clog2(N_REQ)  encoded grantee, registered.

## Operation
- Internal state:
  - `ptr`: highest-priority index for the next turn.
  - `cur`: current grantee.
  - `credit`: W_WIDTH-bit packets remaining in the turn.
  - FSM with two states, IDLE and BUSY.
- Pick function: `ptr` is expanded to a mask of bits ≥ `ptr`. Pick the lowest set bit of `req & mask`. If that is empty, pick the lowest set bit of `req`.
- IDLE:
  - If `sched_en` is high and `|req` is true, register the pick into `gnt`/`gnt_id`, set `gnt_vld`=1, load `credit` = `weight[pick]` (0 is treated as 1), and go to BUSY.
- BUSY: only `beat_acc & beat_last` (packet end) causes a transition. At packet end:
  - Decrement `credit`.
  - If `credit` was >1, `req[cur]` is still high and `sched_en` is high: keep `cur` (continue the turn).
  - Otherwise rotate: `ptr` = (`cur`+1) mod N_REQ. If `sched_en` is high and some request is pending, pick immediately using the new `ptr` and `req` excluding `cur`. If nothing else is pending, re-pick `cur` when `req[cur]` is high; the new turn reloads credit.
  - If nothing is eligible or `sched_en` is low, clear `gnt`/`gnt_vld` and go to IDLE.
- `beat_acc` with `gnt_vld`=0 is ignored. A `req` drop mid-packet is a protocol violation; the scheduler ignores it and waits for packet end.
- `weight` changes affect only turns that start afterwards.

## Timing
- Reset values: `gnt`=0, `gnt_vld`=0, `gnt_id`=0, `ptr`=0, `credit`=0, state IDLE. Reset asserted mid-packet clears all outputs asynchronously.
- Grant latency: `req` high in IDLE at edge k gives `gnt_vld` high after edge k+1.
- Back-to-back packets: no bubble. The next grant, whether the same or a new requester, is visible in the cycle after the edge that accepts the last beat.
- `gnt` is stable for the whole packet. It changes only on a packet-end edge or on reset.
- If `sched_en` falls mid-packet, the grant is held to packet end, then the block goes to IDLE.

## Configuration
- `TX_WRR_WEIGHT_EN` defined: weights are used as described above.
- Not defined: the `weight` port remains but is ignored, credit is fixed at 1, and the block is plain packet-level round-robin.

## Structure
- Shared package `tx_sched_pkg`:
  - state enum `{IDLE, BUSY}`;
  - constant `TX_SCHED_W_DEF`;
  - function mapping weight 0→1.
- One sub-module, `rr_mask_pick`: combinational, parameterized by `N_REQ`. Inputs `req`, `ptr`; outputs one-hot `pick`, `pick_id`, `none`. It is instantiated once.
- The FSM, credit counter and pointer live in the top module.

## Test plan
- Reset then single request: `req`=0100 → `gnt`=0100, `gnt_id`=2, `gnt_vld` one cycle later. Assert reset mid-packet → all outputs 0 immediately.
- Plain RR with `weight`=1 for all and `req`=1111 with 1-beat packets → grant order 0,1,2,3,0, with no idle cycles.
- Weights `{3,1,2,1}` (req3..0) with `req`=1111 and 2-beat packets → per round, packets granted 1×0, 2×1, 1×2, 3×3. `gnt` is constant within each packet.
- Weight 0 and early exit: `weight[1]`=0 → treated as 1. With `weight[0]`=4, drop `req[0]` after its 2nd packet → rotate to requester 1 at the next packet end.
- `sched_en` dropped mid-packet → packet completes, then `gnt_vld`=0. Re-raise → grant resumes from `ptr` = previous `cur`+1.
- Build without `TX_WRR_WEIGHT_EN` and weights `{3,1,2,1}` → pure order 0,1,2,3.
